// File: rtl/front_panel_debounce.sv
// Front-panel pushbutton conditioning: per-button two-flop synchronizer and
// debounce FSM producing a clean active-high level and a one-cycle press strobe.

module front_panel_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic pulse
);
  // state        | meaning
  // RELEASED     | button accepted as released, watching for a low sample
  // PRESS_WAIT   | low seen, counting stable low samples
  // PRESSED      | button accepted as pressed, watching for a high sample
  // RELEASE_WAIT | high seen, counting stable high samples
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= raw_n;
      s     <= sync1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    case (state)
      RELEASED: begin
        if (!s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it changes on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      level <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end
  end
endmodule

module front_panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run_n,
  input  logic Continue_n,
  input  logic ContinueIR_n,
  output logic Run,
  output logic Continue,
  output logic ContinueIR,
  output logic Run_pulse,
  output logic Continue_pulse,
  output logic ContinueIR_pulse
);
  front_panel_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk   (Clk),
    .rst   (Reset),
    .raw_n (Run_n),
    .level (Run),
    .pulse (Run_pulse)
  );

  front_panel_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue (
    .clk   (Clk),
    .rst   (Reset),
    .raw_n (Continue_n),
    .level (Continue),
    .pulse (Continue_pulse)
  );

  front_panel_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue_ir (
    .clk   (Clk),
    .rst   (Reset),
    .raw_n (ContinueIR_n),
    .level (ContinueIR),
    .pulse (ContinueIR_pulse)
  );
endmodule

// File: tb/tb_front_panel_debounce.sv
// Scoreboard bench for front_panel_debounce with DEBOUNCE_CYCLES=4: stimulus
// queues expected outputs per cycle and expected pulses; a monitor pops and compares.

module tb_front_panel_debounce;
  logic Clk;
  logic Reset;
  logic Run_n, Continue_n, ContinueIR_n;
  logic Run, Continue, ContinueIR;
  logic Run_pulse, Continue_pulse, ContinueIR_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      name;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
  } pexp_t;

  exp_t  exp_q[$];
  pexp_t pulse_q[$];

  front_panel_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Run_n            (Run_n),
    .Continue_n       (Continue_n),
    .ContinueIR_n     (ContinueIR_n),
    .Run              (Run),
    .Continue         (Continue),
    .ContinueIR       (ContinueIR),
    .Run_pulse        (Run_pulse),
    .Continue_pulse   (Continue_pulse),
    .ContinueIR_pulse (ContinueIR_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  function automatic logic [5:0] outs();
    return {Run, Continue, ContinueIR, Run_pulse, Continue_pulse, ContinueIR_pulse};
  endfunction

  function automatic void expect_at(int c, logic [5:0] v, string n);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.name = n;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_pulse(int c, logic [2:0] m);
    pexp_t p;
    p.cyc = c;
    p.mask = m;
    pulse_q.push_back(p);
  endfunction

  // Monitor: compares queued per-cycle expectations and every observed pulse.
  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.name, e.cyc, cyc);
      end else if (outs() !== e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d outputs %b, expected %b", e.name, cyc, outs(), e.val);
      end
    end
    if (Run_pulse || Continue_pulse || ContinueIR_pulse) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d pulses %b, expected none",
                 cyc, {Run_pulse, Continue_pulse, ContinueIR_pulse});
      end else begin
        pexp_t p;
        p = pulse_q.pop_front();
        if (p.cyc != cyc || p.mask !== {Run_pulse, Continue_pulse, ContinueIR_pulse}) begin
          errors++;
          $display("FAIL pulse: cycle %0d pulses %b, expected cycle %0d pulses %b",
                   cyc, {Run_pulse, Continue_pulse, ContinueIR_pulse}, p.cyc, p.mask);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    int t;
    Reset = 1'b1;
    Run_n = 1'b1;
    Continue_n = 1'b1;
    ContinueIR_n = 1'b1;
    step(3);
    expect_at(cyc + 1, 6'b000000, "reset_state");
    step(2);

    // Power-on: all released for 20 cycles
    Reset = 1'b0;
    t = cyc;
    expect_at(t + 1, 6'b000000, "power_on_1");
    expect_at(t + 10, 6'b000000, "power_on_10");
    expect_at(t + 20, 6'b000000, "power_on_20");
    step(20);

    // Clean Run press, then release
    t = cyc;
    Run_n = 1'b0;
    expect_at(t + 6, 6'b000000, "clean_press_before");
    expect_at(t + 7, 6'b100100, "clean_press_rise");
    expect_at(t + 8, 6'b100000, "clean_press_pulse_end");
    expect_pulse(t + 7, 3'b100);
    step(10);
    t = cyc;
    Run_n = 1'b1;
    expect_at(t + 6, 6'b100000, "clean_release_before");
    expect_at(t + 7, 6'b000000, "clean_release_fall");
    step(10);

    // Bouncy Continue press: low 3, high 1, then held low
    t = cyc;
    Continue_n = 1'b0;
    step(3);
    Continue_n = 1'b1;
    step(1);
    Continue_n = 1'b0;
    expect_at(t + 7, 6'b000000, "bouncy_press_no_early");
    expect_at(t + 10, 6'b000000, "bouncy_press_before");
    expect_at(t + 11, 6'b010010, "bouncy_press_rise");
    expect_at(t + 12, 6'b010000, "bouncy_press_pulse_end");
    expect_pulse(t + 11, 3'b010);
    step(10);
    t = cyc;
    Continue_n = 1'b1;
    expect_at(t + 7, 6'b000000, "bouncy_press_release");
    step(10);

    // Bouncy ContinueIR release: high 2, low 1, then held high
    t = cyc;
    ContinueIR_n = 1'b0;
    expect_at(t + 7, 6'b001001, "ir_press_rise");
    expect_pulse(t + 7, 3'b001);
    step(10);
    ContinueIR_n = 1'b1;
    step(2);
    ContinueIR_n = 1'b0;
    step(1);
    ContinueIR_n = 1'b1;
    expect_at(t + 14, 6'b001000, "bouncy_release_hold_a");
    expect_at(t + 16, 6'b001000, "bouncy_release_hold_b");
    expect_at(t + 19, 6'b001000, "bouncy_release_before");
    expect_at(t + 20, 6'b000000, "bouncy_release_fall");
    step(15);

    // Reset during PRESS_WAIT with Run held; must re-debounce from scratch
    t = cyc;
    Run_n = 1'b0;
    step(5);
    Reset = 1'b1;
    expect_at(t + 6, 6'b000000, "reset_mid_debounce");
    step(2);
    Reset = 1'b0;
    t = cyc;
    expect_at(t + 6, 6'b000000, "after_reset_before");
    expect_at(t + 7, 6'b100100, "after_reset_rise");
    expect_at(t + 8, 6'b100000, "after_reset_pulse_end");
    expect_pulse(t + 7, 3'b100);
    step(10);

    // Asynchronous reset while pressed: outputs drop without a clock edge
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset: outputs %b, expected 000000", outs());
    end
    step(1);
    Run_n = 1'b1;
    step(1);
    Reset = 1'b0;
    step(10);

    // Simultaneous press on all three, then release Run only
    t = cyc;
    Run_n = 1'b0;
    Continue_n = 1'b0;
    ContinueIR_n = 1'b0;
    expect_at(t + 6, 6'b000000, "simul_before");
    expect_at(t + 7, 6'b111111, "simul_rise");
    expect_at(t + 8, 6'b111000, "simul_pulse_end");
    expect_pulse(t + 7, 3'b111);
    step(10);
    Run_n = 1'b1;
    expect_at(t + 17, 6'b011000, "simul_run_release");
    expect_at(t + 20, 6'b011000, "simul_others_held");
    step(12);
    Continue_n = 1'b1;
    ContinueIR_n = 1'b1;
    step(10);

    for (int i = 0; i < 50 && (exp_q.size() > 0 || pulse_q.size() > 0); i++) step(1);
    checks++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations and %0d pulses pending, expected 0",
               exp_q.size(), pulse_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
